// File: rtl/sss_rd_seq_if.sv
// Purpose : bundles the start/abort controls, the SSS RAM read port and the
//           output sample stream of the SSS readout sequencer.
// Ports   : master = sequencer side (drives RAM enable/address and the sample stream),
//           slave  = environment side (drives start/abort, RAM data and downstream ready).
interface sss_rd_seq_if #(
   parameter int pDAT_W = 4
);
   // control
   logic              istart;
   logic [3:0]        iseq_idx;
   logic [3:0]        irep;
   logic              iabort;
   // RAM read port
   logic              oram_en;
   logic [10:0]       oaddr;
   logic [pDAT_W-1:0] iram_dat;
   // sample stream and status
   logic              oval;
   logic              irdy;
   logic [pDAT_W-1:0] odat;
   logic              osop;
   logic              oeop;
   logic              obusy;
   logic              odone;
   logic              oerr;

   modport master (
      input  istart, iseq_idx, irep, iabort, iram_dat, irdy,
      output oram_en, oaddr, oval, odat, osop, oeop, obusy, odone, oerr
   );

   modport slave (
      output istart, iseq_idx, irep, iabort, iram_dat, irdy,
      input  oram_en, oaddr, oval, odat, osop, oeop, obusy, odone, oerr
   );
endinterface

// File: rtl/sss_rd_seq.sv
// Purpose : reads one stored SSS sequence (irep+1 passes) out of RAM as a valid/ready sample stream.
// Latency : istart in cycle 0 -> first RAM read in cycle 1 -> first oval in cycle 3; one sample/cycle after.
// Backpr. : 2-entry output FIFO; RAM reads are only issued when the FIFO is sure to have room for the data.
// Ports   : iclk/irst (sync, active-high) plain; io_seq (master modport) carries
//           istart/iseq_idx/irep/iabort, the RAM port oram_en/oaddr/iram_dat and the
//           stream oval/irdy/odat/osop/oeop plus status obusy/odone/oerr.
module sss_rd_seq #(
   parameter int pDAT_W   = 4,
   parameter int pSEQ_LEN = 64,
   parameter int pSEQ_NUM = 16
) (
   input  logic         iclk,
   input  logic         irst,
   sss_rd_seq_if.master io_seq
);

   localparam int LEN_W = (pSEQ_LEN > 1) ? $clog2(pSEQ_LEN) : 1;
   localparam int ENT_W = pDAT_W + 2;   // {dat, sop, eop}

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   logic [LEN_W-1:0]  r_k;
   logic [3:0]        r_pass;
   logic [10:0]       r_base;
   logic [10:0]       r_addr;
   logic              r_inflt;
   logic              r_inflt_sop;
   logic              r_inflt_eop;
   logic [ENT_W-1:0]  r_mem [2];
   logic              r_wp;
   logic              r_rp;
   logic [1:0]        r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_pop;
   logic              w_push;
   logic              w_kill;
   logic              w_start;
   logic              w_seq_ok;
   logic              w_last_k;
   logic              w_ram_en;
   logic [2:0]        w_outst;
   logic [1:0]        w_cnt_nxt;
   logic [10:0]       w_base;

   assign w_pop     = (r_cnt != 2'd0) && io_seq.irdy;
   assign w_push    = r_inflt;
   assign w_kill    = io_seq.iabort && (r_state != IDLE);
   // abort wins over a simultaneous start
   assign w_start   = (r_state == IDLE) && io_seq.istart && !io_seq.iabort;
   assign w_seq_ok  = int'(io_seq.iseq_idx) < pSEQ_NUM;
   assign w_last_k  = (r_k == LEN_W'(pSEQ_LEN - 1));
   assign w_base    = 11'(io_seq.iseq_idx) << LEN_W;
   assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

   // Entries owned by the FIFO (stored + the read whose data is on iram_dat),
   // crediting the sample leaving this cycle. The read enable has to see this
   // cycle's pop, otherwise the 3-cycle read loop could not sustain 1 sample/cycle
   // with only two entries; that is why oram_en is combinational.
   assign w_outst  = {1'b0, r_cnt} + {2'b00, r_inflt} - {2'b00, w_pop};
   assign w_ram_en = (r_state == RUN) && !irst && !io_seq.iabort && (w_outst < 3'd2);

   assign io_seq.oram_en = w_ram_en;
   assign io_seq.oaddr   = r_addr;
   assign io_seq.oval    = (r_cnt != 2'd0);
   assign {io_seq.odat, io_seq.osop, io_seq.oeop} = r_mem[r_rp];
   assign io_seq.obusy   = r_busy;
   assign io_seq.odone   = r_done;
   assign io_seq.oerr    = r_err;

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_pass      <= '0;
         r_base      <= '0;
         r_addr      <= '0;
         r_inflt     <= 1'b0;
         r_inflt_sop <= 1'b0;
         r_inflt_eop <= 1'b0;
         r_mem[0]    <= '0;
         r_mem[1]    <= '0;
         r_wp        <= 1'b0;
         r_rp        <= 1'b0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;

         // output FIFO and read-return pipeline
         if (w_kill) begin
            // data of a read still on iram_dat is dropped by clearing r_inflt
            r_cnt   <= '0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_inflt <= 1'b0;
         end else begin
            if (w_push) begin
               r_mem[r_wp] <= {io_seq.iram_dat, r_inflt_sop, r_inflt_eop};
               r_wp        <= ~r_wp;
            end
            if (w_pop) begin
               r_rp <= ~r_rp;
            end
            r_cnt       <= w_cnt_nxt;
            r_inflt     <= w_ram_en;
            r_inflt_sop <= (r_k == '0);
            r_inflt_eop <= w_last_k;
         end

         case (r_state)
            IDLE: begin
               if (w_start) begin
                  if (w_seq_ok) begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                     r_base  <= w_base;
                     r_addr  <= w_base;
                     r_k     <= '0;
                     r_pass  <= io_seq.irep;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_kill) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_ram_en) begin
                  if (w_last_k) begin
                     if (r_pass == 4'd0) begin
                        // last read issued; address is left on the final sample
                        r_state <= DRAIN;
                     end else begin
                        r_pass <= r_pass - 4'd1;
                        r_k    <= '0;
                        r_addr <= r_base;
                     end
                  end else begin
                     r_k    <= r_k + 1'b1;
                     r_addr <= r_addr + 11'd1;
                  end
               end
            end
            DRAIN: begin
               // no reads are issued here, so an empty FIFO next cycle means nothing is left
               if (w_kill) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_cnt_nxt == 2'd0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sss_rd_seq.sv
// Purpose : scoreboard bench for sss_rd_seq; expected addresses and samples are queued
//           at start time and a negedge monitor pops/compares them as the DUT presents them.
module tb_sss_rd_seq;

   localparam int DW  = 4;
   localparam int LEN = 64;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic          sop;
      logic          eop;
   } smp_t;

   logic iclk = 1'b0;
   logic irst;
   always #5 iclk = ~iclk;

   sss_rd_seq_if #(.pDAT_W(DW)) u_if ();
   sss_rd_seq_if #(.pDAT_W(DW)) u_if8 ();

   sss_rd_seq #(.pDAT_W(DW), .pSEQ_LEN(LEN), .pSEQ_NUM(16)) u_dut (
      .iclk   (iclk),
      .irst   (irst),
      .io_seq (u_if.master)
   );

   sss_rd_seq #(.pDAT_W(DW), .pSEQ_LEN(LEN), .pSEQ_NUM(8)) u_dut8 (
      .iclk   (iclk),
      .irst   (irst),
      .io_seq (u_if8.master)
   );

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   exp_addr[$];
   smp_t exp_out[$];
   int   xfer_cnt   = 0;
   int   done_cnt   = 0;
   int   first_oval = -1;
   int   last_xfer  = -1;
   int   done_cyc   = -1;
   int   tb_iss     = 0;
   int   tb_pop     = 0;
   int   c0         = 0;
   int   d0         = 0;
   logic rnd        = 1'b0;
   logic prev_stall = 1'b0;
   logic prev_kill  = 1'b0;
   logic [DW+1:0] prev_smp = '0;

   function automatic logic [DW-1:0] ram_f(input int a);
      logic [31:0] t;
      t = 32'((a * 5) ^ (a >> 3));
      return t[DW-1:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // RAM model: data valid one cycle after the read enable
   always @(posedge iclk) begin
      if (u_if.oram_en) u_if.iram_dat <= ram_f(int'(u_if.oaddr));
   end

   always @(posedge iclk) cyc <= cyc + 1;

   // monitor / scoreboard
   always @(negedge iclk) begin
      smp_t e;
      if (u_if.oram_en) begin
         check("ram_en_room", 32'((tb_iss - tb_pop - ((u_if.oval && u_if.irdy) ? 1 : 0)) < 2), 1);
         if (exp_addr.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL oaddr_unexpected: got %0d, expected no read", u_if.oaddr);
         end else begin
            check("oaddr", 32'(u_if.oaddr), exp_addr.pop_front());
         end
         tb_iss++;
      end
      if (u_if.oval && u_if.irdy) begin
         if (exp_out.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sample_unexpected: got %0d, expected no sample", u_if.odat);
         end else begin
            e = exp_out.pop_front();
            check("odat", 32'(u_if.odat), 32'(e.dat));
            check("osop", 32'(u_if.osop), 32'(e.sop));
            check("oeop", 32'(u_if.oeop), 32'(e.eop));
         end
         tb_pop++;
         xfer_cnt++;
         last_xfer = cyc;
      end
      if (u_if.oval && first_oval < 0) first_oval = cyc;
      if (u_if.odone) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_stall && !prev_kill) begin
         check("hold_oval", 32'(u_if.oval), 1);
         check("hold_smp", 32'({u_if.odat, u_if.osop, u_if.oeop}), 32'(prev_smp));
      end
      prev_stall = u_if.oval && !u_if.irdy;
      prev_kill  = irst || u_if.iabort;
      prev_smp   = {u_if.odat, u_if.osop, u_if.oeop};
   end

   task automatic tick();
      @(posedge iclk);
      #1;
      if (rnd) u_if.irdy = 1'($urandom_range(0, 1));
   endtask

   task automatic clr_stats();
      xfer_cnt   = 0;
      first_oval = -1;
      last_xfer  = -1;
      done_cyc   = -1;
      d0         = done_cnt;
   endtask

   task automatic flush();
      exp_addr.delete();
      exp_out.delete();
      tb_iss = 0;
      tb_pop = 0;
   endtask

   task automatic push_exp(input int seq, input int rep);
      smp_t s;
      for (int p = 0; p <= rep; p++) begin
         for (int k = 0; k < LEN; k++) begin
            exp_addr.push_back(seq * LEN + k);
            s.dat = ram_f(seq * LEN + k);
            s.sop = (k == 0);
            s.eop = (k == LEN - 1);
            exp_out.push_back(s);
         end
      end
   endtask

   task automatic do_start(input int seq, input int rep);
      u_if.istart   = 1'b1;
      u_if.iseq_idx = 4'(seq);
      u_if.irep     = 4'(rep);
      c0 = cyc;
      tick();
      u_if.istart = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (done_cnt > d0) break;
         tick();
      end
      check(nm, 32'(done_cnt - d0), 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ram_en"}, 32'(u_if.oram_en), 0);
      check({tag, "_oaddr"},  32'(u_if.oaddr),   0);
      check({tag, "_oval"},   32'(u_if.oval),    0);
      check({tag, "_odat"},   32'(u_if.odat),    0);
      check({tag, "_osop"},   32'(u_if.osop),    0);
      check({tag, "_oeop"},   32'(u_if.oeop),    0);
      check({tag, "_obusy"},  32'(u_if.obusy),   0);
      check({tag, "_odone"},  32'(u_if.odone),   0);
      check({tag, "_oerr"},   32'(u_if.oerr),    0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      irst           = 1'b1;
      u_if.istart    = 1'b0;
      u_if.iseq_idx  = '0;
      u_if.irep      = '0;
      u_if.iabort    = 1'b0;
      u_if.irdy      = 1'b1;
      u_if8.istart   = 1'b0;
      u_if8.iseq_idx = '0;
      u_if8.irep     = '0;
      u_if8.iabort   = 1'b0;
      u_if8.irdy     = 1'b1;
      u_if8.iram_dat = '0;
      repeat (3) tick();
      check_zero("rst");
      irst = 1'b0;
      tick();

      // seq 3, one pass, irdy=1: exact cycle timing
      clr_stats();
      push_exp(3, 0);
      do_start(3, 0);
      wait_done("t1_done", 300);
      check("t1_first_oval", 32'(first_oval - c0), 3);
      check("t1_last_xfer",  32'(last_xfer - c0), 66);
      check("t1_done_cyc",   32'(done_cyc - c0), 67);
      check("t1_xfers",      32'(xfer_cnt), 64);
      check("t1_q_empty",    32'(exp_out.size()), 0);
      check("t1_busy_off",   32'(u_if.obusy), 0);
      tick();

      // seq 3, three passes: wraps 255->192 twice
      clr_stats();
      push_exp(3, 2);
      do_start(3, 2);
      wait_done("t2_done", 600);
      check("t2_xfers",   32'(xfer_cnt), 192);
      check("t2_q_empty", 32'(exp_out.size()), 0);
      check("t2_addr_q",  32'(exp_addr.size()), 0);
      tick();

      // seq 15 with random irdy; a start while busy must be ignored
      clr_stats();
      rnd = 1'b1;
      push_exp(15, 0);
      do_start(15, 0);
      repeat (10) tick();
      check("t3_busy", 32'(u_if.obusy), 1);
      u_if.istart   = 1'b1;
      u_if.iseq_idx = 4'd5;
      tick();
      u_if.istart = 1'b0;
      check("t3_no_err", 32'(u_if.oerr), 0);
      wait_done("t3_done", 1000);
      rnd       = 1'b0;
      u_if.irdy = 1'b1;
      check("t3_xfers",   32'(xfer_cnt), 64);
      check("t3_q_empty", 32'(exp_out.size()), 0);
      tick();

      // abort around the 20th transfer, then a clean run
      clr_stats();
      push_exp(7, 1);
      do_start(7, 1);
      for (int i = 0; i < 300; i++) begin
         if (xfer_cnt >= 20) break;
         tick();
      end
      check("t4_reach20", 32'(xfer_cnt >= 20), 1);
      u_if.iabort = 1'b1;
      tick();
      u_if.iabort = 1'b0;
      flush();
      @(negedge iclk);
      check("t4_oval_off", 32'(u_if.oval), 0);
      check("t4_busy_off", 32'(u_if.obusy), 0);
      repeat (6) tick();
      check("t4_no_done", 32'(done_cnt - d0), 0);
      clr_stats();
      push_exp(1, 0);
      do_start(1, 0);
      wait_done("t4_rerun_done", 300);
      check("t4_rerun_xfers", 32'(xfer_cnt), 64);
      tick();

      // 8-sequence instance: index 9 is rejected
      u_if8.iseq_idx = 4'd9;
      u_if8.istart   = 1'b1;
      tick();
      u_if8.istart = 1'b0;
      @(negedge iclk);
      check("t5_oerr",     32'(u_if8.oerr), 1);
      check("t5_busy",     32'(u_if8.obusy), 0);
      tick();
      @(negedge iclk);
      check("t5_oerr_end", 32'(u_if8.oerr), 0);
      check("t5_busy_end", 32'(u_if8.obusy), 0);
      tick();

      // reset in the middle of a stalled run
      clr_stats();
      u_if.irdy = 1'b0;
      push_exp(2, 0);
      do_start(2, 0);
      repeat (8) tick();
      check("t6_stalled", 32'(u_if.oval), 1);
      irst = 1'b1;
      tick();
      irst = 1'b0;
      flush();
      @(negedge iclk);
      check_zero("t6");
      u_if.irdy = 1'b1;
      tick();
      clr_stats();
      push_exp(0, 0);
      do_start(0, 0);
      wait_done("t6_rerun_done", 300);
      check("t6_rerun_xfers", 32'(xfer_cnt), 64);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sss_rd_seq.md
SSS_RD_SEQ -- requirements
Module: sss_rd_seq

Interface
REQ-001 SHALL have parameter pDAT_W, default 4, sample width of the SSS RAM.
REQ-002 SHALL have parameter pSEQ_LEN, default 64, samples per sequence (power of two).
REQ-003 SHALL have parameter pSEQ_NUM, default 16, sequences stored; pSEQ_LEN*pSEQ_NUM <= 2048.
REQ-004 SHALL have port iclk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port irst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port istart, input, 1, start request pulse.
REQ-007 SHALL have port iseq_idx, input, 4, sequence number, sampled with istart.
REQ-008 SHALL have port irep, input, 4, extra passes (passes = irep+1), sampled with istart.
REQ-009 SHALL have port iabort, input, 1, cancel the current readout.
REQ-010 SHALL have port oram_en, output, 1, RAM read enable (ival of the RAM read port).
REQ-011 SHALL have port oaddr, output, 11, RAM read address.
REQ-012 SHALL have port iram_dat, input, pDAT_W, RAM read data, valid one cycle after oram_en.
REQ-013 SHALL have port oval, output, 1, output sample valid.
REQ-014 SHALL have port irdy, input, 1, downstream ready; transfer when oval and irdy.
REQ-015 SHALL have port odat, output, pDAT_W, output sample.
REQ-016 SHALL have port osop / oeop, output, 1 each, first / last sample of each pass.
REQ-017 SHALL have port obusy, output, 1, high from accepted start until done or abort.
REQ-018 SHALL have port odone, output, 1, one-cycle pulse after final transfer.
REQ-019 SHALL have port oerr, output, 1, one-cycle pulse on rejected start.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN; RUN issues reads, DRAIN empties the buffer.
REQ-021 SHALL accept istart only in IDLE; istart in RUN/DRAIN SHALL be ignored.
REQ-022 SHALL reject start when iseq_idx >= pSEQ_NUM: pulse oerr next cycle, stay IDLE.
REQ-023 SHALL compute oaddr = iseq_idx*pSEQ_LEN + k, k = 0..pSEQ_LEN-1, zero-extended to 11 bits.
REQ-024 SHALL wrap k to 0 after pSEQ_LEN-1 and decrement the pass counter; after the last pass, go to DRAIN.
REQ-025 SHALL hold a 2-entry output FIFO and assert oram_en only when occupancy + in-flight reads < 2.
REQ-026 SHALL, with irdy held at 1, sustain one sample per cycle; istart at cycle 0 -> oram_en at cycle 1 -> first oval at cycle 3.
REQ-027 SHALL hold odat/osop/oeop/oval stable while oval=1 and irdy=0.
REQ-028 SHALL tag osop on the k=0 sample and oeop on the k=pSEQ_LEN-1 sample of every pass.
REQ-029 SHALL leave DRAIN when the FIFO is empty with no read in flight: pulse odone, return to IDLE and drop obusy.
REQ-030 SHALL, on iabort in RUN/DRAIN, return to IDLE next cycle, flush the FIFO, discard in-flight data, and clear oval/obusy without a pulse on odone.
REQ-031 SHALL give iabort priority over istart in the same cycle; in IDLE, iabort SHALL have no effect.
REQ-032 SHALL keep oram_en=0 in IDLE and DRAIN; oaddr holds its last value.

Reset
REQ-033 SHALL, on irst, enter IDLE and clear the FIFO, counters and in-flight flag.
REQ-034 SHALL drive oram_en, oval, osop, oeop, obusy, odone and oerr to 0, and odat and oaddr to 0, during and after reset.
REQ-035 SHALL give irst priority over every other input, including mid-RUN.

Verification
REQ-036 SHALL verify: iseq_idx=3, irep=0, irdy=1 -> oaddr 192..255; 64 oval samples at cycles 3..66; osop at 3, oeop at 66, odone at 67.
REQ-037 SHALL verify: irep=2 -> 192 transfers; osop/oeop every 64 samples; address wraps 255->192 twice; one odone.
REQ-038 SHALL verify: random irdy (50%) -> no sample lost or duplicated, data matches the RAM model, oram_en never raised with 2 entries outstanding.
REQ-039 SHALL verify: iabort at the 20th transfer -> oval=0 and obusy=0 next cycle, no odone; a following istart runs cleanly.
REQ-040 SHALL verify: iseq_idx=15 accepted (oaddr 960..1023); with pSEQ_NUM=8, iseq_idx=9 -> oerr pulse, obusy stays 0.
REQ-041 SHALL verify: irst mid-RUN with irdy=0 -> all outputs 0 next cycle; istart while busy is ignored.
